seg_capture_4x7: RTL and testbench

//  Receive side of the multiplexed 4-digit 7-segment bus (AN0..AN3, Ca..Cg, DP, all active-low).

---
 rtl/seg4x7_pkg.sv | 39 +++
 rtl/seg7_decode.sv | 41 ++++
 rtl/seg_capture_4x7.sv | 231 +++++++++++++++++++++++
 tb/tb_seg_capture_4x7.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg4x7_pkg.sv
// Shared constants for the 4-digit 7-segment bus capture block: active-low glyph codes,
// the blank pattern, FSM state encodings and a one-hot-to-index helper.
package seg4x7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCapture,
        StHold
    } cap_state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] sel);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of an active-low segment pattern {g..a} into a hex value,
// flagging whether the pattern is a legal glyph or the all-dark blank pattern.
module seg7_decode
    import seg4x7_pkg::*;
(
    input  logic [6:0] cat_i,
    output logic       legal_o,
    output logic       blank_o,
    output logic [3:0] hex_o
);

    always_comb begin
        legal_o = 1'b1;
        blank_o = 1'b0;
        hex_o   = 4'h0;
        case (cat_i)
            SEG_0:     hex_o = 4'h0;
            SEG_1:     hex_o = 4'h1;
            SEG_2:     hex_o = 4'h2;
            SEG_3:     hex_o = 4'h3;
            SEG_4:     hex_o = 4'h4;
            SEG_5:     hex_o = 4'h5;
            SEG_6:     hex_o = 4'h6;
            SEG_7:     hex_o = 4'h7;
            SEG_8:     hex_o = 4'h8;
            SEG_9:     hex_o = 4'h9;
            SEG_A:     hex_o = 4'hA;
            SEG_B:     hex_o = 4'hB;
            SEG_C:     hex_o = 4'hC;
            SEG_D:     hex_o = 4'hD;
            SEG_E:     hex_o = 4'hE;
            SEG_F:     hex_o = 4'hF;
            SEG_BLANK: begin
                legal_o = 1'b0;
                blank_o = 1'b1;
            end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_capture_4x7.sv
// Receive-side monitor for a multiplexed 4-digit 7-segment bus: settles, decodes and holds
// each slot, with freshness timeouts and protocol flags. SEGCAP_INPUT_SYNC_EN adds input syncs.
module seg_capture_4x7
    import seg4x7_pkg::*;
#(
    parameter logic [15:0] SETTLE_CYCLES  = 16'd1000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic       SysClk,
    input  logic       Reset,
    input  logic       AN0,
    input  logic       AN1,
    input  logic       AN2,
    input  logic       AN3,
    input  logic       Ca,
    input  logic       Cb,
    input  logic       Cc,
    input  logic       Cd,
    input  logic       Ce,
    input  logic       Cf,
    input  logic       Cg,
    input  logic       DP,
    output logic [3:0] Digit1,
    output logic [3:0] Digit2,
    output logic [3:0] Digit3,
    output logic [3:0] Digit4,
    output logic       Dp0,
    output logic       Dp1,
    output logic       Dp2,
    output logic       Dp3,
    output logic [3:0] DigitValid,
    output logic       FrameDone,
    output logic       BadPattern,
    output logic       AnConflict
);

    // Bus layout: [11] DP, [10:4] cat {g..a}, [3:0] anodes {AN3..AN0}; all active-low.
    logic [11:0] bus_raw;
    logic [11:0] bus_s;

    assign bus_raw = {DP, Cg, Cf, Ce, Cd, Cc, Cb, Ca, AN3, AN2, AN1, AN0};

`ifdef SEGCAP_INPUT_SYNC_EN
    logic [11:0] sync1_q;
    logic [11:0] sync2_q;

    // Idle bus level is all-high, so synchronizers reset to ones.
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= bus_raw;
            sync2_q <= sync1_q;
        end
    end

    assign bus_s = sync2_q;
`else
    assign bus_s = bus_raw;
`endif

    logic [3:0] an_n;
    logic [7:0] seg_n;
    logic [3:0] sel;
    logic       one_hot;
    logic       multi;

    assign an_n    = bus_s[3:0];
    assign seg_n   = bus_s[11:4];
    assign sel     = ~an_n;
    assign one_hot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    assign multi   = (sel != 4'd0) && !one_hot;

    cap_state_e        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [3:0]        an_prev_q, an_prev_d;
    logic [7:0]        seg_prev_q, seg_prev_d;
    logic [3:0][3:0]   digit_q, digit_d;
    logic [3:0]        dp_q, dp_d;
    logic [3:0]        valid_q, valid_d;
    logic [3:0]        seen_q, seen_d;
    logic [3:0][23:0]  tcnt_q, tcnt_d;
    logic              frame_done_q, frame_done_d;
    logic              bad_q, bad_d;
    logic              conflict_q, conflict_d;

    logic       dec_legal;
    logic       dec_blank;
    logic [3:0] dec_hex;

    // seg_prev_q holds the last sampled pattern, which is the settled one while in CAPTURE.
    seg7_decode u_decode (
        .cat_i   (seg_prev_q[6:0]),
        .legal_o (dec_legal),
        .blank_o (dec_blank),
        .hex_o   (dec_hex)
    );

    logic       an_changed;
    logic       seg_changed;
    logic       reenter;
    logic       capture;
    logic [1:0] slot;
    logic [3:0] wr_legal;
    logic [3:0] wr_clear;

    assign an_changed  = an_n != an_prev_q;
    assign seg_changed = seg_n != seg_prev_q;
    assign slot        = onehot_to_idx(~an_prev_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        an_prev_d    = an_n;
        seg_prev_d   = seg_n;
        digit_d      = digit_q;
        dp_d         = dp_q;
        valid_d      = valid_q;
        tcnt_d       = tcnt_q;
        conflict_d   = 1'b0;
        bad_d        = 1'b0;
        reenter      = 1'b0;
        capture      = 1'b0;
        wr_legal     = 4'd0;
        wr_clear     = 4'd0;

        if (multi) begin
            conflict_d = 1'b1;
            state_d    = StIdle;
            cnt_d      = '0;
        end else begin
            unique case (state_q)
                StIdle:    reenter = 1'b1;
                StSettle: begin
                    if (!one_hot) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (an_changed || seg_changed) begin
                        cnt_d = '0;
                    end else if (cnt_q == SETTLE_CYCLES - 16'd1) begin
                        state_d = StCapture;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StCapture: begin
                    capture = 1'b1;
                    state_d = StHold;
                end
                StHold:    reenter = an_changed;
                default:   state_d = StIdle;
            endcase

            if (reenter) begin
                state_d = one_hot ? StSettle : StIdle;
                cnt_d   = '0;
            end
        end

        if (capture) begin
            if (dec_legal) begin
                wr_legal[slot] = 1'b1;
                digit_d[slot]  = dec_hex;
                dp_d[slot]     = ~seg_prev_q[7];
            end else begin
                wr_clear[slot] = 1'b1;
                bad_d          = !dec_blank;
            end
        end

        // A legal capture beats a same-cycle timeout on that slot.
        for (int k = 0; k < 4; k++) begin
            if (wr_legal[k]) begin
                tcnt_d[k]  = '0;
                valid_d[k] = 1'b1;
            end else begin
                if (tcnt_q[k] != TIMEOUT_CYCLES) tcnt_d[k] = tcnt_q[k] + 24'd1;
                if (wr_clear[k] || (tcnt_q[k] == TIMEOUT_CYCLES)) valid_d[k] = 1'b0;
            end
        end

        // Captures landing on the FrameDone cycle start the next frame.
        frame_done_d = seen_q == 4'hF;
        seen_d       = (frame_done_d ? 4'd0 : seen_q) | wr_legal;
    end

    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            an_prev_q    <= '1;
            seg_prev_q   <= '1;
            digit_q      <= '0;
            dp_q         <= '0;
            valid_q      <= '0;
            seen_q       <= '0;
            tcnt_q       <= '0;
            frame_done_q <= 1'b0;
            bad_q        <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            an_prev_q    <= an_prev_d;
            seg_prev_q   <= seg_prev_d;
            digit_q      <= digit_d;
            dp_q         <= dp_d;
            valid_q      <= valid_d;
            seen_q       <= seen_d;
            tcnt_q       <= tcnt_d;
            frame_done_q <= frame_done_d;
            bad_q        <= bad_d;
            conflict_q   <= conflict_d;
        end
    end

    assign Digit1     = digit_q[0];
    assign Digit2     = digit_q[1];
    assign Digit3     = digit_q[2];
    assign Digit4     = digit_q[3];
    assign Dp0        = dp_q[0];
    assign Dp1        = dp_q[1];
    assign Dp2        = dp_q[2];
    assign Dp3        = dp_q[3];
    assign DigitValid = valid_q;
    assign FrameDone  = frame_done_q;
    assign BadPattern = bad_q;
    assign AnConflict = conflict_q;

endmodule

// File: tb/tb_seg_capture_4x7.sv
// Bench for seg_capture_4x7: directed scenarios followed by random slot/pattern traffic,
// all checked against a slot-level model of the captured display state.
`timescale 1ns/1ps
module tb_seg_capture_4x7;

    localparam int S   = 4;
    localparam int T   = 64;
    localparam int LAT = S + 2;  // one-hot seen -> S settle cycles -> CAPTURE -> write visible

    logic       clk;
    logic       rst;
    logic [3:0] an_n;
    logic [6:0] cat;
    logic       dp_n;
    logic [3:0] d1, d2, d3, d4;
    logic       p0, p1, p2, p3;
    logic [3:0] valid;
    logic       frame_done;
    logic       bad_pat;
    logic       an_conf;

    seg_capture_4x7 #(
        .SETTLE_CYCLES  (16'd4),
        .TIMEOUT_CYCLES (24'd64)
    ) dut (
        .SysClk     (clk),
        .Reset      (rst),
        .AN0        (an_n[0]),
        .AN1        (an_n[1]),
        .AN2        (an_n[2]),
        .AN3        (an_n[3]),
        .Ca         (cat[0]),
        .Cb         (cat[1]),
        .Cc         (cat[2]),
        .Cd         (cat[3]),
        .Ce         (cat[4]),
        .Cf         (cat[5]),
        .Cg         (cat[6]),
        .DP         (dp_n),
        .Digit1     (d1),
        .Digit2     (d2),
        .Digit3     (d3),
        .Digit4     (d4),
        .Dp0        (p0),
        .Dp1        (p1),
        .Dp2        (p2),
        .Dp3        (p3),
        .DigitValid (valid),
        .FrameDone  (frame_done),
        .BadPattern (bad_pat),
        .AnConflict (an_conf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int frames_seen = 0;
    int bad_seen = 0;
    int conf_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_done) frames_seen++;
        if (bad_pat) bad_seen++;
        if (an_conf) conf_seen++;
    end

    // Display model: what each slot should hold, and when it was last freshly captured.
    logic [6:0] glyph [16];
    int         exp_digit [4];
    bit         exp_dp [4];
    bit         exp_vflag [4];
    int         cap_cyc [4];
    bit [3:0]   exp_seen;
    int         exp_frames = 0;
    int         exp_bad = 0;

    int ntotal = 0;
    int nbad = 0;

    function automatic logic [3:0] obs_digit(input int k);
        case (k)
            0:       return d1;
            1:       return d2;
            2:       return d3;
            default: return d4;
        endcase
    endfunction

    function automatic logic obs_dp(input int k);
        case (k)
            0:       return p0;
            1:       return p1;
            2:       return p2;
            default: return p3;
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        ntotal++;
        assert (obs === exp_v) else begin
            nbad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            exp_digit[k] = 0;
            exp_dp[k]    = 1'b0;
            exp_vflag[k] = 1'b0;
            cap_cyc[k]   = 0;
        end
        exp_seen = 4'd0;
    endtask

    task automatic model_cap(input int k, input logic [6:0] pat, input bit dp_lit, input int c);
        int idx = -1;
        for (int i = 0; i < 16; i++) if (glyph[i] == pat) idx = i;
        if (idx >= 0) begin
            exp_digit[k] = idx;
            exp_dp[k]    = dp_lit;
            exp_vflag[k] = 1'b1;
            cap_cyc[k]   = c;
            exp_seen[k]  = 1'b1;
            if (exp_seen == 4'hF) begin
                exp_frames++;
                exp_seen = 4'd0;
            end
        end else begin
            if (pat != 7'h7F) exp_bad++;
            exp_vflag[k] = 1'b0;
        end
    endtask

    // Validity near the timeout boundary is skipped; elsewhere it must match exactly.
    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            int age = cyc - cap_cyc[k];
            chk({tag, "_digit"}, k, 32'(obs_digit(k)), exp_digit[k]);
            chk({tag, "_dp"}, k, 32'(obs_dp(k)), 32'(exp_dp[k]));
            if (!exp_vflag[k]) chk({tag, "_valid"}, k, 32'(valid[k]), 0);
            else if (age < T - 2) chk({tag, "_valid"}, k, 32'(valid[k]), 1);
            else if (age > T + 4) chk({tag, "_valid_timeout"}, k, 32'(valid[k]), 0);
        end
        chk({tag, "_frames"}, 0, frames_seen, exp_frames);
        chk({tag, "_badcnt"}, 0, bad_seen, exp_bad);
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_digit"}, k, 32'(obs_digit(k)), 0);
            chk({tag, "_dp"}, k, 32'(obs_dp(k)), 0);
        end
        chk({tag, "_valid"}, 0, 32'(valid), 0);
        chk({tag, "_pulses"}, 0, {29'd0, frame_done, bad_pat, an_conf}, 0);
    endtask

    task automatic idle(input int n);
        an_n = 4'hF;
        cat  = 7'h7F;
        dp_n = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int k, input logic [6:0] pat, input bit dp_lit, input int hold,
                        input string tag);
        an_n = ~(4'b0001 << k);
        cat  = pat;
        dp_n = ~dp_lit;
        model_cap(k, pat, dp_lit, cyc + LAT);
        repeat (hold) @(posedge clk);
        #1;
        check_all(tag);
        idle(1);
    endtask

    int         c0;
    int         conf_before;
    int         k;
    int         cls;
    logic [6:0] p;

    initial begin
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        model_reset();
        rst  = 1'b1;
        an_n = 4'hF;
        cat  = 7'h7F;
        dp_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        idle(1);

        // Normal refresh: 1,2,3,4 with DP on slot 2, two full frames.
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 4; s++) show(s, glyph[s + 1], s == 2, 8, "scan");
        chk("scan_valid", 0, 32'(valid), 32'hF);
        chk("scan_frames", 0, frames_seen, 2);

        // Pattern changes mid-settle: the settle window restarts.
        idle(2);
        c0   = cyc;
        an_n = 4'b1101;
        cat  = 7'h40;
        dp_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cat = 7'h00;
        repeat (4) @(posedge clk);
        #1;
        chk("settle_restart", 1, 32'(d2), exp_digit[1]);
        model_cap(1, 7'h00, 1'b0, c0 + 9);
        repeat (5) @(posedge clk);
        #1;
        check_all("settle");
        chk("settle_digit8", 1, 32'(d2), 8);
        idle(1);

        // Two anodes low at once.
        an_n = 4'b1100;
        cat  = glyph[7];
        dp_n = 1'b0;
        @(posedge clk);
        #1;
        chk("conflict_pulse", 0, 32'(an_conf), 1);
        repeat (10) @(posedge clk);
        #1;
        check_all("conflict");
        idle(2);
        chk("conflict_clear", 0, 32'(an_conf), 0);

        // Illegal settled pattern on slot 3.
        show(3, 7'h55, 1'b0, 10, "badpat");
        chk("badpat_valid3", 3, 32'(valid[3]), 0);
        chk("badpat_digit4", 3, 32'(d4), 4);

        // Slot 0 refreshed once then starved while 1..3 keep refreshing.
        show(0, glyph[1], 1'b0, 8, "to_start");
        for (int r = 0; r < 4; r++)
            for (int s = 1; s < 4; s++) show(s, glyph[8 + s], 1'b0, 8, "to_run");
        chk("timeout_valid", 0, 32'(valid), 32'hE);

        // Reset in the middle of a settle window.
        idle(1);
        an_n = 4'b1011;
        cat  = glyph[5];
        dp_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        check_reset("rst_edge");
        @(posedge clk);
        #1;
        rst = 1'b0;
        c0  = cyc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_early_cap", 0, 32'(valid), 0);
        model_cap(2, glyph[5], 1'b1, c0 + LAT);
        repeat (5) @(posedge clk);
        #1;
        check_all("post_reset");
        idle(1);

        // Random slot / pattern traffic.
        conf_before = conf_seen;
        for (int i = 0; i < 40; i++) begin
            k   = int'($urandom_range(3, 0));
            cls = int'($urandom_range(19, 0));
            if (cls < 12) p = glyph[$urandom_range(15, 0)];
            else if (cls < 15) p = 7'h7F;
            else p = 7'($urandom);
            show(k, p, 1'($urandom), int'($urandom_range(14, 8)), "rand");
        end
        chk("rand_no_conflict", 0, conf_seen - conf_before, 0);

        $display("test done: total=%0d bad=%0d", ntotal, nbad);
        $finish;
    end

endmodule
